// File: rtl/bram_byte_fifo_ctrl.sv
// rtl/bram_byte_fifo_ctrl.sv - 1024x8 byte FIFO controller around a 1 KB block RAM with registered read
module bram_byte_fifo_ctrl #(
    parameter int READ_ADDRESS_MSB_FROM_DATALSB  = 24,
    parameter int WRITE_ADDRESS_MSB_FROM_DATALSB = 16,
    parameter int WRITE_ENABLE_FROM_DATA         = 20,
    parameter int ALMOST_FULL_LEVEL              = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] count,
    output logic        almost_full,
    output logic [7:0]  bram_wr_addr,
    output logic [31:0] bram_wr_data,
    output logic [7:0]  bram_rd_addr,
    input  logic [31:0] bram_rd_data
);

    logic [9:0]  wr_ptr_q, wr_ptr_d;
    logic [9:0]  rd_ptr_q, rd_ptr_d;
    logic [10:0] mem_cnt_q, mem_cnt_d;
    logic [10:0] count_q, count_d;
    logic        rd_inflight_q;
    logic [1:0]  ob_cnt_q, ob_cnt_d;
    logic [7:0]  ob0_q, ob0_d;
    logic [7:0]  ob1_q, ob1_d;
    logic        almost_full_q, almost_full_d;

    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  ob_occ;
    logic        unused_rd_bits;

    assign unused_rd_bits = ^bram_rd_data[31:8];

    assign in_ready  = (count_q < 11'd1024) & ~rst;
    assign push      = in_valid & in_ready & ~flush;
    assign out_valid = (ob_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = ob0_q;

    // Skid occupancy one cycle ahead: a new read may only launch if its data will find a free slot.
    assign ob_occ = {1'b0, ob_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop};
    assign issue  = (mem_cnt_q != 11'd0) && (ob_occ < 3'd2);

    assign count        = count_q;
    assign almost_full  = almost_full_q;
    assign bram_wr_addr = wr_ptr_q[7:0];
    assign bram_rd_addr = rd_ptr_q[7:0];

    always_comb begin
        bram_wr_data                                       = '0;
        bram_wr_data[7:0]                                  = in_data;
        bram_wr_data[WRITE_ADDRESS_MSB_FROM_DATALSB +: 2]  = wr_ptr_q[9:8];
        bram_wr_data[WRITE_ENABLE_FROM_DATA]               = push;
        bram_wr_data[READ_ADDRESS_MSB_FROM_DATALSB +: 2]   = rd_ptr_q[9:8];
    end

    always_comb begin
        wr_ptr_d      = push  ? wr_ptr_q + 10'd1 : wr_ptr_q;
        rd_ptr_d      = issue ? rd_ptr_q + 10'd1 : rd_ptr_q;
        mem_cnt_d     = mem_cnt_q + {10'd0, push} - {10'd0, issue};
        count_d       = count_q + {10'd0, push} - {10'd0, pop};
        almost_full_d = (count_d >= 11'(ALMOST_FULL_LEVEL));

        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        ob_cnt_d = ob_cnt_q;
        if (pop) begin
            ob0_d    = ob1_q;
            ob_cnt_d = ob_cnt_d - 2'd1;
        end
        // Returning RAM data lands behind whatever survives this cycle's pop.
        if (rd_inflight_q) begin
            if (ob_cnt_d == 2'd0) begin
                ob0_d = bram_rd_data[7:0];
            end else begin
                ob1_d = bram_rd_data[7:0];
            end
            ob_cnt_d = ob_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            count_q       <= count_d;
            rd_inflight_q <= issue;
            ob_cnt_q      <= ob_cnt_d;
            almost_full_q <= almost_full_d;
        end
    end

    always_ff @(posedge clk) begin
        ob0_q <= ob0_d;
        ob1_q <= ob1_d;
    end

endmodule

// File: tb/tb_bram_byte_fifo_ctrl.sv
// tb/tb_bram_byte_fifo_ctrl.sv - directed/random scoreboard bench for bram_byte_fifo_ctrl with a behavioural 1 KB RAM
module tb_bram_byte_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, almost_full;
    logic [7:0]  out_data, bram_wr_addr, bram_rd_addr;
    logic [10:0] count;
    logic [31:0] bram_wr_data, bram_rd_data;

    logic [7:0]  ram [0:1023];
    logic [7:0]  sb [$];
    int          vec = 0;
    int          errs = 0;
    int          cnt_exp = 0;
    logic [9:0]  wp_exp = '0;
    logic        hold_q = 1'b0;
    logic [7:0]  held = '0;
    logic [3:0]  msb_seen = '0;

    always #5 clk = ~clk;

    bram_byte_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full),
        .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data)
    );

    always @(posedge clk) begin
        bram_rd_data <= {24'h0, ram[{bram_wr_data[25:24], bram_rd_addr}]};
        if (bram_wr_data[20]) ram[{bram_wr_data[17:16], bram_wr_addr}] <= bram_wr_data[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic pu, po;
        @(negedge clk);
        pu = in_valid && (cnt_exp < 1024) && !rst && !flush;
        po = out_valid && out_ready;
        chk("count", 32'(count), cnt_exp);
        chk("in_ready", 32'(in_ready), 32'((cnt_exp < 1024) && !rst));
        chk("almost_full", 32'(almost_full), 32'(cnt_exp >= 1000));
        chk("wr_en", 32'(bram_wr_data[20]), 32'(pu));
        if (pu) chk("wr_addr", 32'({bram_wr_data[17:16], bram_wr_addr}), 32'(wp_exp));
        if (hold_q) chk("hold_stable", 32'(out_data), 32'(held));
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
            else begin
                chk("head_data", 32'(out_data), 32'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
        msb_seen[bram_wr_data[25:24]] = 1'b1;
        if (pu) sb.push_back(in_data);
        hold_q = out_valid && !out_ready && !rst && !flush;
        held   = out_data;
        if (rst || flush) begin
            cnt_exp = 0;
            wp_exp  = '0;
            sb.delete();
        end else begin
            cnt_exp = cnt_exp + int'(pu) - int'(po);
            if (pu) wp_exp = wp_exp + 10'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 0);
        tick();
        tick();
        chk("empty_after_drain", 32'(out_valid), 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("reset_count", 32'(count), 0);
        chk("reset_out_valid", 32'(out_valid), 0);

        // Test 1: three pushes, first-word latency
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        chk("lat_not_yet", 32'(out_valid), 0);
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h11);
        chk("three_count", 32'(count), 3);
        drain();

        // Test 2: fill to full, rejected push, ordered drain across all four RAM quarters
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            in_data = 8'(i);
            tick();
        end
        chk("full_count", 32'(count), 1024);
        chk("full_in_ready", 32'(in_ready), 0);
        in_data = 8'hEE;
        out_ready = 1'b1;
        tick();
        chk("full_reject_count", 32'(count), 1023);
        msb_seen = '0;
        drain();
        chk("rd_msb_fields", 32'(msb_seen), 32'hF);

        // Test 3: streaming with wrap
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_data = 8'($urandom);
            tick();
            if (i >= 2) chk("no_bubble", 32'(out_valid), 1);
            chk("stream_count_le3", 32'(count <= 11'd3), 1);
        end
        drain();

        // Test 4: random backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Test 5: flush with a read in flight
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h50 + i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("pre_flush_count", 32'(count), 5);
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        tick();
        chk("flush_inflight_dropped", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data = 8'hAB;
        tick();
        drain();

        // Test 6: reset mid-stream
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        tick();
        tick();
        chk("rst_mid_idle", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data = 8'hC3;
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
